// File: rtl/fetch_defs.sv
// Shared definitions for the instruction-fetch sequencer: state encodings,
// datapath width and the default reset PC.
package fetch_defs;

  typedef enum logic [1:0] {
    FS_RUN   = 2'd0,
    FS_PAUSE = 2'd1,
    FS_FAULT = 2'd2
  } fetch_state_t;

  localparam int          INSTR_W          = 32;
  localparam int          ENTRY_W          = 2 * INSTR_W;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/fetch_fifo2.sv
// Two-entry {pc, instr} FIFO. The head lives in its own register so the
// consumer-facing outputs come straight from flops.
module fetch_fifo2
  import fetch_defs::*;
(
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_flush,
  input  logic               i_push,
  input  logic               i_pop,
  input  logic [ENTRY_W-1:0] i_din,
  output logic [ENTRY_W-1:0] o_head,
  output logic [1:0]         o_count
);

  logic [ENTRY_W-1:0] r_head;
  logic [ENTRY_W-1:0] r_tail;
  logic [1:0]         r_count;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= 2'd0;
    end else if (i_flush) begin
      r_count <= 2'd0;
    end else begin
      case ({i_push, i_pop})
        2'b10: begin
          if (r_count == 2'd0) begin
            r_head  <= i_din;
            r_count <= 2'd1;
          end else if (r_count == 2'd1) begin
            r_tail  <= i_din;
            r_count <= 2'd2;
          end
        end
        2'b01: begin
          if (r_count != 2'd0) begin
            r_head  <= r_tail;
            r_count <= r_count - 2'd1;
          end
        end
        2'b11: begin
          // Simultaneous push/pop keeps the occupancy unchanged.
          if (r_count == 2'd2) begin
            r_head <= r_tail;
            r_tail <= i_din;
          end else begin
            r_head <= i_din;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_head  = r_head;
  assign o_count = r_count;

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the PC, fetches from an async-read
// memory into a 2-entry buffer, and handles redirect, halt and fetch faults.
module fetch_sequencer
  import fetch_defs::*;
#(
  parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
  parameter int          MEM_WORDS = 1024
) (
  input  logic               clk,
  input  logic               reset,
  output logic [31:0]        imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               redirect_valid,
  input  logic [31:0]        redirect_pc,
  input  logic               halt,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [31:0]        out_pc,
  output logic               fault,
  output logic [31:0]        fault_pc,
  output logic [1:0]         dbg_state
);

  // Handshake: the head transfers on a rising edge where out_valid and
  // out_ready are both high; out_instr/out_pc hold while out_ready is low.

  fetch_state_t       r_state;
  fetch_state_t       w_state_nxt;
  logic [31:0]        r_pc;
  logic               r_fault;
  logic [31:0]        r_fault_pc;

  logic               w_legal;
  logic               w_deq;
  logic               w_slot;
  logic               w_enq;
  logic               w_fault_evt;
  logic [1:0]         w_count;
  logic [ENTRY_W-1:0] w_head;

  assign w_legal = (r_pc[1:0] == 2'b00) &&
                   ({2'b00, r_pc[31:2]} < 32'(MEM_WORDS));
  assign w_deq   = out_valid && out_ready;
  assign w_slot  = (w_count != 2'd2) || w_deq;

  always_ff @(posedge clk) begin
    if (reset) r_state <= FS_RUN;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_enq       = 1'b0;
    w_fault_evt = 1'b0;
    if (redirect_valid) begin
      w_state_nxt = halt ? FS_PAUSE : FS_RUN;
    end else begin
      case (r_state)
        FS_RUN: begin
          if (halt) begin
            w_state_nxt = FS_PAUSE;
          end else if (w_slot) begin
            if (w_legal) begin
              w_enq = 1'b1;
            end else begin
              w_fault_evt = 1'b1;
              w_state_nxt = FS_FAULT;
            end
          end
        end
        FS_PAUSE: if (!halt) w_state_nxt = FS_RUN;
        FS_FAULT: ;
        default:  w_state_nxt = FS_RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc       <= RESET_PC;
      r_fault    <= 1'b0;
      r_fault_pc <= 32'h0;
    end else if (redirect_valid) begin
      r_pc    <= redirect_pc;
      r_fault <= 1'b0;
    end else begin
      if (w_enq) r_pc <= r_pc + 32'd4;
      if (w_fault_evt) begin
        r_fault    <= 1'b1;
        r_fault_pc <= r_pc;
      end
    end
  end

  fetch_fifo2 u_fifo (
    .i_clk   (clk),
    .i_reset (reset),
    .i_flush (redirect_valid),
    .i_push  (w_enq),
    .i_pop   (w_deq),
    .i_din   ({r_pc, imem_rdata}),
    .o_head  (w_head),
    .o_count (w_count)
  );

  assign imem_addr = {2'b00, r_pc[31:2]};
  assign out_valid = (w_count != 2'd0);
  assign out_pc    = w_head[ENTRY_W-1:INSTR_W];
  assign out_instr = w_head[INSTR_W-1:0];
  assign fault     = r_fault;
  assign fault_pc  = r_fault_pc;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: streaming and stall sequences checked through an
// expected queue, a vector table for redirect/fault/halt/reset, and a
// MEM_WORDS=4 instance for the out-of-range fault.
module tb_fetch_sequencer;

  localparam logic [31:0] M0 = 32'h402182B3;
  localparam logic [31:0] M1 = 32'h00311293;
  localparam logic [31:0] M2 = 32'h002282E3;
  localparam logic [31:0] M3 = 32'hA5000003;
  localparam logic [31:0] M7 = 32'h000052B7;

  logic        clk = 1'b0;
  logic [31:0] mem [0:1023];

  logic        reset, redirect_valid, halt, out_ready;
  logic [31:0] redirect_pc, imem_addr, imem_rdata, out_instr, out_pc, fault_pc;
  logic        out_valid, fault;
  logic [1:0]  dbg_state;

  logic        b_reset, b_redirect_valid, b_halt, b_out_ready;
  logic [31:0] b_redirect_pc, b_imem_addr, b_imem_rdata, b_out_instr, b_out_pc, b_fault_pc;
  logic        b_out_valid, b_fault;
  logic [1:0]  b_dbg_state;

  int total = 0;
  int bad   = 0;
  logic [63:0] exp_q[$];

  always #5 clk = ~clk;

  assign imem_rdata   = (imem_addr   < 32'd1024) ? mem[imem_addr[9:0]]   : 32'h0;
  assign b_imem_rdata = (b_imem_addr < 32'd1024) ? mem[b_imem_addr[9:0]] : 32'h0;

  fetch_sequencer #(.RESET_PC(32'h0), .MEM_WORDS(1024)) u_dut (
    .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halt(halt),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_pc(out_pc), .fault(fault), .fault_pc(fault_pc), .dbg_state(dbg_state)
  );

  fetch_sequencer #(.RESET_PC(32'h0), .MEM_WORDS(4)) u_dut_small (
    .clk(clk), .reset(b_reset), .imem_addr(b_imem_addr), .imem_rdata(b_imem_rdata),
    .redirect_valid(b_redirect_valid), .redirect_pc(b_redirect_pc), .halt(b_halt),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_instr(b_out_instr),
    .out_pc(b_out_pc), .fault(b_fault), .fault_pc(b_fault_pc), .dbg_state(b_dbg_state)
  );

  typedef struct {
    logic        rst;
    logic        redir;
    logic [31:0] rpc;
    logic        hlt;
    logic        rdy;
    logic        e_valid;
    logic        chk_data;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
    logic        e_fault;
    logic        chk_fpc;
    logic [31:0] e_fpc;
    logic [31:0] e_addr;
    logic [1:0]  e_state;
  } vec_t;

  vec_t tbl[16];

  function automatic vec_t mk(logic rst, logic redir, logic [31:0] rpc, logic hlt,
                              logic rdy, logic e_valid, logic chk_data,
                              logic [31:0] e_pc, logic [31:0] e_instr, logic e_fault,
                              logic chk_fpc, logic [31:0] e_fpc, logic [31:0] e_addr,
                              logic [1:0] e_state);
    vec_t v;
    v.rst = rst; v.redir = redir; v.rpc = rpc; v.hlt = hlt; v.rdy = rdy;
    v.e_valid = e_valid; v.chk_data = chk_data; v.e_pc = e_pc; v.e_instr = e_instr;
    v.e_fault = e_fault; v.chk_fpc = chk_fpc; v.e_fpc = e_fpc; v.e_addr = e_addr;
    v.e_state = e_state;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pop_chk(input string nm, input logic [63:0] act);
    logic [63:0] e;
    if (exp_q.size() == 0) begin
      chk({nm, "_underflow"}, 64'd1, 64'd0);
    end else begin
      e = exp_q.pop_front();
      chk(nm, act, e);
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'hA500_0000 | i;
    mem[0] = M0; mem[1] = M1; mem[2] = M2; mem[7] = M7;

    // Reset values on both instances.
    reset = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0; halt = 1'b0; out_ready = 1'b0;
    b_reset = 1'b1; b_redirect_valid = 1'b0; b_redirect_pc = 32'h0; b_halt = 1'b0;
    b_out_ready = 1'b0;
    step(); step();
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_instr", 64'(out_instr), 64'd0);
    chk("rst_pc", 64'(out_pc), 64'd0);
    chk("rst_fault", 64'(fault), 64'd0);
    chk("rst_fault_pc", 64'(fault_pc), 64'd0);
    chk("rst_addr", 64'(imem_addr), 64'd0);
    chk("rst_state", 64'(dbg_state), 64'd0);
    chk("rst_b_valid", 64'(b_out_valid), 64'd0);

    // Back-to-back stream with out_ready held high.
    exp_q.push_back({32'h0, M0});
    exp_q.push_back({32'h4, M1});
    exp_q.push_back({32'h8, M2});
    reset = 1'b0; out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("stream_valid", 64'(out_valid), 64'd1);
      if (out_valid) pop_chk("stream_data", {out_pc, out_instr});
    end

    // Consumer stall: buffer fills, head holds, then drains in order.
    reset = 1'b1; out_ready = 1'b0;
    step();
    reset = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("stall_valid", 64'(out_valid), 64'd1);
      chk("stall_head", {out_pc, out_instr}, {32'h0, M0});
    end
    chk("stall_addr", 64'(imem_addr), 64'd2);
    exp_q.push_back({32'h0, M0});
    exp_q.push_back({32'h4, M1});
    exp_q.push_back({32'h8, M2});
    exp_q.push_back({32'hC, M3});
    for (int k = 0; k < 4; k++) begin
      chk("drain_valid", 64'(out_valid), 64'd1);
      if (out_valid) pop_chk("drain_data", {out_pc, out_instr});
      out_ready = 1'b1;
      step();
    end

    // Redirect / fault / halt / reset vector table, starting from reset.
    tbl[0]  = mk(0,0,32'h0 ,0,0, 1,1,32'h0 ,M0, 0,1,32'h0,32'd1,2'd0);
    tbl[1]  = mk(0,0,32'h0 ,0,0, 1,1,32'h0 ,M0, 0,1,32'h0,32'd2,2'd0);
    tbl[2]  = mk(0,0,32'h0 ,0,1, 1,1,32'h4 ,M1, 0,1,32'h0,32'd3,2'd0);
    tbl[3]  = mk(0,1,32'h1C,0,1, 0,0,32'h0 ,0 , 0,1,32'h0,32'd7,2'd0);
    tbl[4]  = mk(0,0,32'h0 ,0,1, 1,1,32'h1C,M7, 0,1,32'h0,32'd8,2'd0);
    tbl[5]  = mk(0,1,32'h6 ,0,1, 0,0,32'h0 ,0 , 0,1,32'h0,32'd1,2'd0);
    tbl[6]  = mk(0,0,32'h0 ,0,1, 0,0,32'h0 ,0 , 1,1,32'h6,32'd1,2'd2);
    tbl[7]  = mk(0,0,32'h0 ,0,1, 0,0,32'h0 ,0 , 1,1,32'h6,32'd1,2'd2);
    tbl[8]  = mk(0,1,32'h0 ,0,1, 0,0,32'h0 ,0 , 0,0,32'h0,32'd0,2'd0);
    tbl[9]  = mk(0,0,32'h0 ,0,1, 1,1,32'h0 ,M0, 0,0,32'h0,32'd1,2'd0);
    tbl[10] = mk(0,0,32'h0 ,0,0, 1,1,32'h0 ,M0, 0,0,32'h0,32'd2,2'd0);
    tbl[11] = mk(0,0,32'h0 ,1,1, 1,1,32'h4 ,M1, 0,0,32'h0,32'd2,2'd1);
    tbl[12] = mk(0,0,32'h0 ,1,1, 0,0,32'h0 ,0 , 0,0,32'h0,32'd2,2'd1);
    tbl[13] = mk(0,0,32'h0 ,1,1, 0,0,32'h0 ,0 , 0,0,32'h0,32'd2,2'd1);
    tbl[14] = mk(1,0,32'h0 ,1,1, 0,1,32'h0 ,0 , 0,1,32'h0,32'd0,2'd0);
    tbl[15] = mk(0,0,32'h0 ,0,1, 1,1,32'h0 ,M0, 0,1,32'h0,32'd1,2'd0);

    reset = 1'b1; out_ready = 1'b0; halt = 1'b0; redirect_valid = 1'b0;
    step();
    for (int r = 0; r < 16; r++) begin
      reset = tbl[r].rst; redirect_valid = tbl[r].redir; redirect_pc = tbl[r].rpc;
      halt = tbl[r].hlt; out_ready = tbl[r].rdy;
      step();
      chk($sformatf("row%0d_valid", r), 64'(out_valid), 64'(tbl[r].e_valid));
      chk($sformatf("row%0d_fault", r), 64'(fault), 64'(tbl[r].e_fault));
      chk($sformatf("row%0d_addr", r), 64'(imem_addr), 64'(tbl[r].e_addr));
      chk($sformatf("row%0d_state", r), 64'(dbg_state), 64'(tbl[r].e_state));
      if (tbl[r].chk_data)
        chk($sformatf("row%0d_data", r), {out_pc, out_instr}, {tbl[r].e_pc, tbl[r].e_instr});
      if (tbl[r].chk_fpc)
        chk($sformatf("row%0d_fault_pc", r), 64'(fault_pc), 64'(tbl[r].e_fpc));
    end
    redirect_valid = 1'b0; halt = 1'b0;

    // MEM_WORDS=4: last legal word is delivered, then the next PC faults.
    b_reset = 1'b0; b_redirect_valid = 1'b1; b_redirect_pc = 32'h0C; b_out_ready = 1'b1;
    step();
    b_redirect_valid = 1'b0;
    chk("small_redir_valid", 64'(b_out_valid), 64'd0);
    exp_q.push_back({32'hC, M3});
    step();
    chk("small_valid", 64'(b_out_valid), 64'd1);
    if (b_out_valid) pop_chk("small_data", {b_out_pc, b_out_instr});
    chk("small_nofault", 64'(b_fault), 64'd0);
    step();
    chk("small_fault", 64'(b_fault), 64'd1);
    chk("small_fault_pc", 64'(b_fault_pc), 64'h10);
    chk("small_fault_valid", 64'(b_out_valid), 64'd0);
    chk("small_state", 64'(b_dbg_state), 64'd2);

    chk("sb_empty", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
